fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch buffer between the PC/instruction-memory stage (IF) and the decode stage (ID).
- Captures {pc, instr} pairs produced by IF into a small circular FIFO and presents the oldest pair to ID.
- Decouples IF from ID stalls: IF keeps fetching until the queue is full.
- On a control-flow redirect, all buffered (wrong-path) entries are discarded.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden)

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset; sampled on posedge clk, 0 = reset
- push_valid  input  1  IF presents a fetched pair this cycle
- push_pc  input  32  PC of the fetched instruction
- push_instr  input  32  fetched instruction word
- push_ready  output  1  queue can accept; drives En_PC of the PC register
- pop_ready  input  1  ID accepts the head entry this cycle; 0 = ID stall
- pop_valid  output  1  head entry is valid
- pop_pc  output  32  PC of the head entry
- pop_instr  output  32  instruction word of the head entry
- flush  input  1  redirect: discard all entries
- count  output  CW  current occupancy, 0..DEPTH

Behaviour:
- Storage:
  - DEPTH x 64-bit array of {pc, instr}.
  - rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count register is CW bits.
- Reset (reset==0 at posedge):
  - rd_ptr = wr_ptr = 0, count = 0.
  - Array contents are don't-care.
  - Reset overrides flush, push and pop in the same cycle.
- Status outputs (combinational from registered state only):
  - push_ready = (count != DEPTH).
  - pop_valid = (count != 0).
  - push_ready does not depend on pop_ready (no comb path ID -> IF).
- Head outputs:
  - When pop_valid=1: pop_pc/pop_instr = array[rd_ptr].
  - When pop_valid=0: pop_pc = 32'h0 and pop_instr = 32'h0 (nop bubble).
- Accept conditions:
  - push_fire = push_valid & push_ready.
  - pop_fire = pop_ready & pop_valid.
- Normal cycle (flush=0):
  - push_fire: write {push_pc, push_instr} at wr_ptr, then wr_ptr+1.
  - pop_fire: rd_ptr+1.
  - count +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a pair pushed at edge N appears on pop_* after edge N (earliest pop at edge N+1). No same-cycle bypass when empty.
- Full: push_ready=0; a push_valid is ignored even if pop_fire occurs that cycle. IF must hold the pair, since En_PC=0 holds the PC.
- Empty: pop_ready is ignored; rd_ptr and count are unchanged.
- Simultaneous push and pop with 0<count<DEPTH: both occur; count is unchanged and pointers advance independently.
- Wrap-around: pointers roll over from DEPTH-1 to 0. FIFO order is preserved across the wrap.
- Flush (flush=1, reset=1):
  - rd_ptr = wr_ptr = 0, count = 0.
  - A push or pop in the same cycle is discarded; the queue is empty next cycle.
  - push_ready still reflects pre-flush state during the flush cycle.
- Arithmetic: pointer increments truncate to log2(DEPTH) bits. count never exceeds DEPTH and never goes below 0.
- No X propagation: pop_* are forced to 0 when empty, regardless of array contents.

Test Plan:
- Reset then idle: reset=0 for 2 cycles -> count=0, pop_valid=0, push_ready=1, pop_pc=0, pop_instr=0.
- Fill with ID stalled: push 0x3000/0x24010001, 0x3004/0x24020002, 0x3008, 0x300C with pop_ready=0 -> count=4, push_ready=0. A 5th push of 0x3010 is ignored. pop_pc=0x3000.
- Drain in order: from full, pop_ready=1 for 4 cycles -> pop_pc = 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles, then pop_valid=0, count=0.
- Streaming and wrap: push and pop every cycle for 10 cycles with pc 0x3000+4k after one pre-fill -> count stays 1. Outputs are in order across the pointer wrap, with no loss or duplication.
- Flush precedence: count=3 with head 0x3008; assert flush together with push 0x3020 and pop_ready=1 -> next cycle count=0, pop_valid=0. Next push 0x3040 appears as head one cycle later.
- Reset mid-operation: count=2, then reset=0 together with push_valid=1 and flush=0 -> next cycle count=0 and the push is not stored.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {pc, instr} pairs between IF and ID, with flush on redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_valid,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr,
  output logic          push_ready,
  input  logic          pop_ready,
  output logic          pop_valid,
  output logic [31:0]   pop_pc,
  output logic [31:0]   pop_instr,
  input  logic          flush,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push_fire, pop_fire;
  assign push_ready = count != FULL;
  assign pop_valid  = count != '0;
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_ready & pop_valid;
  // Empty head presents a nop bubble so stale array contents never leak to ID.
  assign pop_pc     = pop_valid ? mem[rd_ptr][63:32] : '0;
  assign pop_instr  = pop_valid ? mem[rd_ptr][31:0]  : '0;
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_fire) - CW'(pop_fire);
    end
  end
  always_ff @(posedge clk)
    if (reset && !flush && push_fire) mem[wr_ptr] <= {push_pc, push_instr};
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed vectors for fetch_queue, checked before and after each edge.
module tb_fetch_queue;
  logic        clk = 0, reset, push_valid, pop_ready, flush;
  logic [31:0] push_pc, push_instr, pop_pc, pop_instr;
  logic        push_ready, pop_valid;
  logic [2:0]  count;
  int tests = 0, fails = 0;

  typedef struct {
    logic rn, pv, pr, fl;
    logic [31:0] pc, ins;
    logic [2:0] cnt;
    logic rdy, vld;
    logic [31:0] hpc, hins;
  } vec_t;
  vec_t vq[$];

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_pc(push_pc),
    .push_instr(push_instr), .push_ready(push_ready), .pop_ready(pop_ready),
    .pop_valid(pop_valid), .pop_pc(pop_pc), .pop_instr(pop_instr),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // 0x3000 -> 0x24010001, 0x3004 -> 0x24020002, ...
  function automatic logic [31:0] ins(logic [31:0] pc);
    return 32'h2400_0000 + ((pc - 32'h2FFC) >> 2) * 32'h0001_0001;
  endfunction

  function automatic void add(logic rn, pv, logic [31:0] pc, logic pr, fl,
                              logic [2:0] cnt, logic rdy, vld, logic [31:0] hpc);
    vec_t v;
    v.rn = rn; v.pv = pv; v.pc = pc; v.ins = pv ? ins(pc) : 32'h0;
    v.pr = pr; v.fl = fl; v.cnt = cnt; v.rdy = rdy; v.vld = vld;
    v.hpc = hpc; v.hins = vld ? ins(hpc) : 32'h0;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    reset = 0; push_valid = 0; pop_ready = 0; flush = 0; push_pc = 0; push_instr = 0;
    // reset and idle
    add(0,0,0,0,0, 0,1,0,0);
    add(0,0,0,0,0, 0,1,0,0);
    // fill with ID stalled; 5th push ignored
    add(1,1,32'h3000,0,0, 1,1,1,32'h3000);
    add(1,1,32'h3004,0,0, 2,1,1,32'h3000);
    add(1,1,32'h3008,0,0, 3,1,1,32'h3000);
    add(1,1,32'h300C,0,0, 4,0,1,32'h3000);
    add(1,1,32'h3010,0,0, 4,0,1,32'h3000);
    // drain; push while full is ignored even though a pop fires
    add(1,1,32'h3010,1,0, 3,1,1,32'h3004);
    add(1,0,0,1,0, 2,1,1,32'h3008);
    add(1,0,0,1,0, 1,1,1,32'h300C);
    add(1,0,0,1,0, 0,1,0,0);
    add(1,0,0,1,0, 0,1,0,0);
    // streaming across several pointer wraps
    add(1,1,32'h3000,0,0, 1,1,1,32'h3000);
    for (int k = 1; k <= 10; k++)
      add(1,1,32'h3000 + 4*k,1,0, 1,1,1,32'h3000 + 4*k);
    // flush, refill, reach count=3 with head 0x3008
    add(1,0,0,0,1, 0,1,0,0);
    add(1,1,32'h3000,0,0, 1,1,1,32'h3000);
    add(1,1,32'h3004,0,0, 2,1,1,32'h3000);
    add(1,1,32'h3008,0,0, 3,1,1,32'h3000);
    add(1,1,32'h300C,0,0, 4,0,1,32'h3000);
    add(1,0,0,1,0, 3,1,1,32'h3004);
    add(1,0,0,1,0, 2,1,1,32'h3008);
    add(1,1,32'h3010,0,0, 3,1,1,32'h3008);
    // flush beats push and pop in the same cycle
    add(1,1,32'h3020,1,1, 0,1,0,0);
    add(1,1,32'h3040,0,0, 1,1,1,32'h3040);
    add(1,1,32'h3044,0,0, 2,1,1,32'h3040);
    // reset beats push
    add(0,1,32'h3048,0,0, 0,1,0,0);
    add(1,0,0,0,0, 0,1,0,0);
    add(1,1,32'h3050,0,0, 1,1,1,32'h3050);
    add(1,0,0,1,0, 0,1,0,0);

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rn; push_valid = vq[i].pv; push_pc = vq[i].pc;
      push_instr = vq[i].ins; pop_ready = vq[i].pr; flush = vq[i].fl;
      #1;
      // before the edge, outputs must still show the previous state whatever the inputs
      if (i > 0) begin
        chk("pre_push_ready", i, 32'(push_ready), 32'(vq[i-1].rdy));
        chk("pre_pop_valid",  i, 32'(pop_valid),  32'(vq[i-1].vld));
        chk("pre_pop_pc",     i, pop_pc,          vq[i-1].hpc);
      end
      @(posedge clk); #1;
      chk("count",      i, 32'(count),      32'(vq[i].cnt));
      chk("push_ready", i, 32'(push_ready), 32'(vq[i].rdy));
      chk("pop_valid",  i, 32'(pop_valid),  32'(vq[i].vld));
      chk("pop_pc",     i, pop_pc,          vq[i].hpc);
      chk("pop_instr",  i, pop_instr,       vq[i].hins);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
